// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester IDs,
// default bus widths and the starvation-counter width helper.
package mem_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_LS = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational next-grant selection for the memory-port arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise LS priority with a fetch starvation guard.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
)(
    input  logic             i_if_req,
    input  logic             i_if_flush,
    input  logic             i_ls_req,
`ifdef MEM_ARB_RR_EN
    input  logic             i_last_id,
`else
    input  logic [CNT_W-1:0] i_starve_cnt,
`endif
    output logic             o_gnt_valid,
    output logic             o_gnt_id
);

    logic w_if_ok;

    // A flushed fetch is never eligible for a new grant.
    assign w_if_ok = i_if_req & ~i_if_flush;

`ifdef MEM_ARB_RR_EN
    // Round-robin: the requester granted last loses a tie.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = REQ_IF;
        if (w_if_ok && i_ls_req) begin
            o_gnt_valid = 1'b1;
            o_gnt_id    = (i_last_id == REQ_LS) ? REQ_IF : REQ_LS;
        end else if (i_ls_req) begin
            o_gnt_valid = 1'b1;
            o_gnt_id    = REQ_LS;
        end else if (w_if_ok) begin
            o_gnt_valid = 1'b1;
            o_gnt_id    = REQ_IF;
        end else begin
            o_gnt_valid = 1'b0;
            o_gnt_id    = REQ_IF;
        end
    end
`else
    // LS wins unless fetch has already waited through STARVE_MAX LS grants.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = REQ_IF;
        if (i_ls_req && ((i_starve_cnt < CNT_W'(STARVE_MAX)) || !i_if_req)) begin
            o_gnt_valid = 1'b1;
            o_gnt_id    = REQ_LS;
        end else if (w_if_ok) begin
            o_gnt_valid = 1'b1;
            o_gnt_id    = REQ_IF;
        end else begin
            o_gnt_valid = 1'b0;
            o_gnt_id    = REQ_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, dropping flushed fetches.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of LS priority with starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned STARVE_MAX = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     if_rd_addr,
    input  logic                  if_rd_enable,
    input  logic                  if_flush,
    output logic [DATA_W-1:0]     if_rd_data,
    output logic                  if_rd_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_enable,
    input  logic                  ls_write,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wstrb,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  ls_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_enable,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic [ADDR_W-1:0] r_if_addr;
    logic              w_idle_exit;

    assign w_idle_exit = (r_state == ST_IDLE) && w_gnt_valid;

`ifdef MEM_ARB_RR_EN
    logic r_last_id;

    // Remember who was granted last so the other side wins the next tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_id <= REQ_IF;
        end else if (w_idle_exit) begin
            r_last_id <= w_gnt_id;
        end else begin
            r_last_id <= r_last_id;
        end
    end

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_prio (
        .i_if_req    (if_rd_enable),
        .i_if_flush  (if_flush),
        .i_ls_req    (ls_enable),
        .i_last_id   (r_last_id),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );
`else
    logic [CNT_W-1:0] r_starve_cnt;

    // Count LS grants taken while fetch waits; cleared when fetch is served or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if ((w_state_nxt == ST_GNT_IF) || !if_rd_enable) begin
                r_starve_cnt <= '0;
            end else if ((w_state_nxt == ST_GNT_LS) && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_prio (
        .i_if_req     (if_rd_enable),
        .i_if_flush   (if_flush),
        .i_ls_req     (ls_enable),
        .i_starve_cnt (r_starve_cnt),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );
`endif

    // Grant state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hold the fetch address so a drained request keeps a stable address after redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_addr <= '0;
        end else if (w_idle_exit && (w_gnt_id == REQ_IF)) begin
            r_if_addr <= if_rd_addr;
        end else begin
            r_if_addr <= r_if_addr;
        end
    end

    // Next-state logic; every grant returns through IDLE to give requesters a bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = (w_gnt_id == REQ_LS) ? ST_GNT_LS : ST_GNT_IF;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT_IF: begin
                if (mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end else if (if_flush) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_GNT_IF;
                end
            end
            ST_GNT_LS, ST_DRAIN: begin
                w_state_nxt = mem_ready ? ST_IDLE : r_state;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory-side mux and response routing; everything is zero outside a grant.
    always_comb begin
        mem_addr    = '0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_enable  = 1'b0;
        if_rd_data  = '0;
        if_rd_ready = 1'b0;
        ls_rdata    = '0;
        ls_ready    = 1'b0;
        case (r_state)
            ST_GNT_IF: begin
                mem_enable  = 1'b1;
                mem_addr    = if_rd_addr;
                if_rd_data  = mem_rdata;
                if_rd_ready = mem_ready & ~if_flush;
            end
            ST_DRAIN: begin
                mem_enable = 1'b1;
                mem_addr   = r_if_addr;
            end
            ST_GNT_LS: begin
                mem_enable = 1'b1;
                mem_addr   = ls_addr;
                mem_write  = ls_write;
                mem_wdata  = ls_wdata;
                mem_wstrb  = ls_wstrb;
                ls_rdata   = mem_rdata;
                ls_ready   = mem_ready;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions plus
// hand-written arbitration, flush and reset sequences, with a response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_rd_addr = 32'h0;
    logic        if_rd_enable = 1'b0;
    logic        if_flush = 1'b0;
    logic [31:0] if_rd_data;
    logic        if_rd_ready;
    logic [31:0] ls_addr = 32'h0;
    logic        ls_enable = 1'b0;
    logic        ls_write = 1'b0;
    logic [31:0] ls_wdata = 32'h0;
    logic [3:0]  ls_wstrb = 4'h0;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_enable;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_rd_addr(if_rd_addr), .if_rd_enable(if_rd_enable), .if_flush(if_flush),
        .if_rd_data(if_rd_data), .if_rd_ready(if_rd_ready),
        .ls_addr(ls_addr), .ls_enable(ls_enable), .ls_write(ls_write),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_enable(mem_enable), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: ready after mem_lat extra cycles of a held request.
    int mem_lat = 1;
    int r_mcnt;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) r_mcnt <= 0;
        else if (mem_enable && !mem_ready) r_mcnt <= r_mcnt + 1;
        else r_mcnt <= 0;
    end
    assign mem_ready = mem_enable && (r_mcnt == mem_lat);
    assign mem_rdata = mem_ready ? model_rd(mem_addr) : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected completions, in order.
    typedef struct {
        logic        is_ls;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (if_rd_ready || ls_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", {30'd0, if_rd_ready, ls_ready}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ready_kind", {30'd0, if_rd_ready, ls_ready},
                          mon_e.is_ls ? 32'd1 : 32'd2);
                    if (mon_e.chk)
                        check("rd_data", mon_e.is_ls ? ls_rdata : if_rd_data, mon_e.data);
                end
            end
        end
    end

    typedef struct {
        logic        is_ls;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ctl"}, {27'd0, mem_wstrb == 4'h0 ? 1'b0 : 1'b1, mem_enable, mem_write,
                              if_rd_ready, ls_ready}, 32'd0);
        check({tag, "_rdata"}, if_rd_data | ls_rdata, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int  waited;
        bit  seen;
        bit  ok;
        mem_lat = v.lat;
        step();
        if (v.is_ls) begin
            ls_addr = v.addr; ls_write = v.write; ls_wdata = v.wdata; ls_wstrb = v.wstrb;
            ls_enable = 1'b1;
        end else begin
            if_rd_addr = v.addr;
            if_rd_enable = 1'b1;
        end
        sb.push_back('{v.is_ls, !v.write, v.exp_data});
        @(negedge clk);
        check("vec_idle_on_request", {31'd0, mem_enable}, 32'd0);
        seen = 1'b0; ok = 1'b1; waited = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (!mem_enable || mem_addr !== v.addr || mem_write !== v.write) ok = 1'b0;
            if (v.is_ls && (mem_wdata !== v.wdata || mem_wstrb !== v.wstrb)) ok = 1'b0;
            if (if_rd_ready || ls_ready) seen = 1'b1;
        end
        check("vec_ready_cycle", waited, v.lat + 1);
        check("vec_mem_fields", {31'd0, ok}, 32'd1);
        step();
        if_rd_enable = 1'b0; ls_enable = 1'b0; ls_write = 1'b0;
        @(negedge clk);
        check("vec_bubble_idle", {31'd0, mem_enable}, 32'd0);
    endtask

    // Wait for n completion pulses, bounded.
    task automatic wait_ready(input int n, input int bound, output int cycles);
        int got;
        got = 0; cycles = 0;
        while (got < n && cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (if_rd_ready || ls_ready) got++;
        end
        check("wait_ready_count", got, n);
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234, 4'h3, 2, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 1, 32'hA5A5_585E};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 32'hA5A5_5B5E};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0208, 32'hCAFE_F00D, 4'hF, 4, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 3, 32'h5A5A_A5A6};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'hA5A5_5A5A};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset");
        step();
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {31'd0, mem_enable}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous requests: LS first, fetch two cycles after ls_ready
        mem_lat = 2;
        step();
        if_rd_addr = 32'h300; ls_addr = 32'h400; ls_write = 1'b0;
        if_rd_enable = 1'b1; ls_enable = 1'b1;
        sb.push_back('{1'b1, 1'b1, 32'hA5A5_5E5A});
        sb.push_back('{1'b0, 1'b1, 32'hA5A5_595A});
        @(negedge clk);
        @(negedge clk);
        check("simul_first_grant_addr", mem_enable ? mem_addr : 32'hFFFF_FFFF, 32'h400);
        wait_ready(1, 20, k);
        check("simul_ls_ready_cycle", k, 2);
        step();
        ls_enable = 1'b0;
        @(negedge clk);
        check("simul_bubble", {31'd0, mem_enable}, 32'd0);
        @(negedge clk);
        check("simul_if_grant_addr", mem_enable ? mem_addr : 32'hFFFF_FFFF, 32'h300);
        wait_ready(1, 20, k);
        step();
        if_rd_enable = 1'b0;

        // Flush one cycle into GNT_IF, latency 3: drain, no fetch response
        mem_lat = 3;
        step();
        if_rd_addr = 32'h700; if_rd_enable = 1'b1;
        step();
        @(negedge clk);
        check("flush_grant", {31'd0, mem_enable}, 32'd1);
        step();
        if_flush = 1'b1; if_rd_enable = 1'b0;
        step();
        if_flush = 1'b0;
        @(negedge clk);
        check("drain_hold", {30'd0, mem_enable, mem_ready}, 32'd2);
        @(negedge clk);
        check("drain_ready", {30'd0, mem_ready, if_rd_ready}, 32'd2);
        @(negedge clk);
        check("drain_to_idle", {31'd0, mem_enable}, 32'd0);

        // Flush arriving together with mem_ready drops the response
        mem_lat = 1;
        step();
        if_rd_addr = 32'h740; if_rd_enable = 1'b1;
        step();
        step();
        if_flush = 1'b1; if_rd_enable = 1'b0;
        @(negedge clk);
        check("flush_same_cycle", {30'd0, mem_ready, if_rd_ready}, 32'd2);
        step();
        if_flush = 1'b0;
        @(negedge clk);
        check("flush_same_idle", {31'd0, mem_enable}, 32'd0);

        // Flush in IDLE with no LS request: no grant that cycle
        step();
        if_rd_addr = 32'h800; if_rd_enable = 1'b1; if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        sb.push_back('{1'b0, 1'b1, 32'hA5A5_525A});
        @(negedge clk);
        check("flush_idle_no_grant", {31'd0, mem_enable}, 32'd0);
        @(negedge clk);
        check("flush_idle_then_grant", {31'd0, mem_enable}, 32'd1);
        wait_ready(1, 20, k);
        step();
        if_rd_enable = 1'b0;

        // Starvation guard: 4 LS grants, 1 fetch, repeated
        mem_lat = 1;
        step();
        if_rd_addr = 32'h600; ls_addr = 32'h500; ls_write = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) sb.push_back('{1'b1, 1'b1, 32'hA5A5_5F5A});
            sb.push_back('{1'b0, 1'b1, 32'hA5A5_5C5A});
        end
        if_rd_enable = 1'b1; ls_enable = 1'b1;
        wait_ready(10, 200, k);
        check("starve_total_cycles", k, 30);
        step();
        if_rd_enable = 1'b0; ls_enable = 1'b0;
        @(negedge clk);
        check("starve_sb_empty", sb.size(), 32'd0);

        // Reset asserted mid-store
        mem_lat = 5;
        step();
        ls_addr = 32'h900; ls_write = 1'b1; ls_wdata = 32'h55; ls_wstrb = 4'h1; ls_enable = 1'b1;
        step();
        step();
        #2;
        check("midstore_granted", {31'd0, mem_enable}, 32'd1);
        reset = 1'b0;
        #1;
        check_outs_zero("reset_async");
        ls_enable = 1'b0; ls_write = 1'b0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_release_idle", {31'd0, mem_enable}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
